// File: rtl/traffic_gen_chk.sv
// traffic_gen_chk: pushes words into the main FIFO, drains NDEST channels and checks routing.
// Define TGC_SEQ_CHECK_EN to also check per-channel payload order in mode 0.
module traffic_gen_chk #(
  parameter int BW = 6,
  parameter int SEL_W = 2,
  parameter int CNT_W = 8,
  parameter int TO_CYC = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         mode,
  input  logic [CNT_W-1:0]             num_words,
  input  logic                         main_full,
  output logic                         main_wr,
  output logic [BW-1:0]                main_data,
  input  logic [(2**SEL_W)-1:0]        d_empty,
  input  logic [(2**SEL_W)-1:0]        d_error,
  output logic [(2**SEL_W)-1:0]        d_rd,
  input  logic [(2**SEL_W)*BW-1:0]     d_data,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         timeout,
  output logic [CNT_W-1:0]             sent_cnt,
  output logic [CNT_W-1:0]             recv_cnt,
  output logic [CNT_W-1:0]             err_cnt
);
  localparam int NDEST = 2**SEL_W;
  localparam int PW = BW - SEL_W;
  localparam int IW = $clog2(TO_CYC + 1);
  typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic mode_q, mode_d, wr_q, wr_d, done_q, done_d, pass_q, pass_d, to_q, to_d;
  logic [CNT_W-1:0] num_q, num_d, sent_q, sent_d, recv_q, recv_d, err_q, err_d, rd_n, err_n;
  logic [IW-1:0] idle_q, idle_d;
  logic [7:0] lfsr_q, lfsr_d, lfsr_nx;
  logic [NDEST-1:0] rd_q, rd_d;
  logic [BW-1:0] data_q, data_d, word, ch;
`ifdef TGC_SEQ_CHECK_EN
  logic [NDEST-1:0][PW-1:0] exp_q, exp_d;
`endif

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign lfsr_nx = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign word = mode_q ? lfsr_q[BW-1:0] : {sent_q[SEL_W-1:0], sent_q[PW-1:0]};
  assign rd_d = (state_q == SEND || state_q == DRAIN) ? ~d_empty & ~d_error : '0;

  always_comb begin
    rd_n = '0;
    err_n = '0;
    ch = '0;
`ifdef TGC_SEQ_CHECK_EN
    exp_d = exp_q;
`endif
    for (int i = 0; i < NDEST; i++) begin
      if (rd_q[i]) begin
        ch = d_data[i*BW +: BW];
        rd_n = rd_n + CNT_W'(1);
        if (ch[BW-1 -: SEL_W] != SEL_W'(i)) err_n = err_n + CNT_W'(1);
`ifdef TGC_SEQ_CHECK_EN
        if (!mode_q) begin
          if (ch[PW-1:0] != exp_q[i]) err_n = err_n + CNT_W'(1);
          exp_d[i] = ch[PW-1:0] + PW'(NDEST);
        end
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    num_d = num_q;
    sent_d = sent_q;
    recv_d = sat_add(recv_q, rd_n);
    err_d = sat_add(err_q, err_n);
    idle_d = idle_q;
    lfsr_d = lfsr_q;
    data_d = data_q;
    wr_d = 1'b0;
    done_d = 1'b0;
    pass_d = pass_q;
    to_d = to_q;
    case (state_q)
      IDLE: if (start) begin
        mode_d = mode;
        num_d = num_words;
        sent_d = '0;
        recv_d = '0;
        err_d = '0;
        idle_d = '0;
        lfsr_d = 8'h01;
        pass_d = 1'b0;
        to_d = 1'b0;
        state_d = (num_words == '0) ? DONE : SEND;
      end
      SEND: if (!main_full) begin
        wr_d = 1'b1;
        data_d = word;
        sent_d = sat_add(sent_q, CNT_W'(1));
        lfsr_d = lfsr_nx;
        if (sent_d == num_q) state_d = DRAIN;
      end
      DRAIN: begin
        idle_d = (|rd_q) ? '0 : idle_q + IW'(1);
        if (recv_q == sent_q && !(|rd_q)) state_d = DONE;
        else if (idle_d == IW'(TO_CYC)) begin
          to_d = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        done_d = 1'b1;
        pass_d = (err_q == '0) && !to_q && (recv_q == sent_q);
        state_d = IDLE;
      end
    endcase
  end

`ifdef TGC_SEQ_CHECK_EN
  // First word on channel i must carry payload i.
  always_ff @(posedge clk)
    if (reset) exp_q <= '0;
    else if (state_q == IDLE && start) for (int i = 0; i < NDEST; i++) exp_q[i] <= PW'(i);
    else exp_q <= exp_d;
`endif

  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      mode_q <= 1'b0;
      num_q <= '0;
      sent_q <= '0;
      recv_q <= '0;
      err_q <= '0;
      idle_q <= '0;
      lfsr_q <= 8'h01;
      data_q <= '0;
      wr_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      to_q <= 1'b0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      num_q <= num_d;
      sent_q <= sent_d;
      recv_q <= recv_d;
      err_q <= err_d;
      idle_q <= idle_d;
      lfsr_q <= lfsr_d;
      data_q <= data_d;
      wr_q <= wr_d;
      done_q <= done_d;
      pass_q <= pass_d;
      to_q <= to_d;
      rd_q <= rd_d;
    end

  assign main_wr = wr_q;
  assign main_data = data_q;
  assign d_rd = rd_d;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign pass = pass_q;
  assign timeout = to_q;
  assign sent_cnt = sent_q;
  assign recv_cnt = recv_q;
  assign err_cnt = err_q;
endmodule

// File: tb/tb_traffic_gen_chk.sv
// tb_traffic_gen_chk: directed bench with a queue model of the main FIFO, demux and destination FIFOs.
module tb_traffic_gen_chk;
  localparam int BW = 6, SEL_W = 2, CNT_W = 8, TO = 64, ND = 4;
`ifdef TGC_SEQ_CHECK_EN
  localparam int MIS_ERR = 4, SWAP_ERR = 2;
`else
  localparam int MIS_ERR = 1, SWAP_ERR = 0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0, main_full = 1'b0;
  logic [7:0] num_words = '0;
  logic main_wr, busy, done, pass, timeout;
  logic [5:0] main_data;
  logic [3:0] d_empty = '1, d_error = '0, d_rd;
  logic [23:0] d_data = '0;
  logic [7:0] sent_cnt, recv_cnt, err_cnt;
  logic clr = 1'b0, mis_en = 1'b0, swap_en = 1'b0;
  logic mis_done = 1'b0, swap_done = 1'b0, stash_v = 1'b0;
  logic [5:0] stash;
  logic [5:0] fq [ND][$];
  logic [5:0] plog [$];
  logic [5:0] m1 [6] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h11, 6'h23};
  int dones = 0, total = 0, bad = 0;

  always #5 clk = ~clk;

  traffic_gen_chk #(.BW(BW), .SEL_W(SEL_W), .CNT_W(CNT_W), .TO_CYC(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .num_words(num_words),
    .main_full(main_full), .main_wr(main_wr), .main_data(main_data),
    .d_empty(d_empty), .d_error(d_error), .d_rd(d_rd), .d_data(d_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .sent_cnt(sent_cnt), .recv_cnt(recv_cnt), .err_cnt(err_cnt));

  // Pops happen before pushes so a word pushed at an edge is visible one cycle later.
  always @(posedge clk) begin : model
    int c;
    if (clr) begin
      for (int i = 0; i < ND; i++) fq[i].delete();
      plog.delete();
      stash_v = 1'b0;
      swap_done = 1'b0;
      mis_done = 1'b0;
      dones = 0;
    end else begin
      for (int i = 0; i < ND; i++)
        if (d_rd[i] && fq[i].size() != 0) d_data[i*BW +: BW] <= fq[i].pop_front();
      if (main_wr) begin
        plog.push_back(main_data);
        c = int'(main_data[5:4]);
        if (mis_en && !mis_done && c == 2) begin
          c = 1;
          mis_done = 1'b1;
        end
        if (swap_en && !swap_done && c == 0 && !stash_v) begin
          stash = main_data;
          stash_v = 1'b1;
        end else begin
          fq[c].push_back(main_data);
          if (stash_v && c == 0) begin
            fq[0].push_back(stash);
            stash_v = 1'b0;
            swap_done = 1'b1;
          end
        end
      end
      if (done) dones++;
    end
    for (int i = 0; i < ND; i++) d_empty[i] <= fq[i].size() == 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic m, input logic [7:0] n);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    mode = m;
    num_words = n;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (dones == 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", dones, 1);
  endtask

  task automatic wait_pushes(input int n);
    int k = 0;
    while (plog.size() < n && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("push_wait", plog.size() >= n, 1);
  endtask

  task automatic chk_log(input int n, input logic m);
    chk("log_len", plog.size(), n);
    for (int i = 0; i < n && i < plog.size(); i++) begin
      logic [7:0] k;
      logic [5:0] e;
      k = 8'(i);
      if (m) e = m1[i];
      else e = {k[1:0], k[3:0]};
      chk($sformatf("word%0d", i), plog[i], e);
    end
  endtask

  task automatic chk_result(input string tag, input int s, input int r, input int e, input logic p, input logic t);
    chk({tag, "_sent"}, sent_cnt, s);
    chk({tag, "_recv"}, recv_cnt, r);
    chk({tag, "_err"}, err_cnt, e);
    chk({tag, "_pass"}, pass, p);
    chk({tag, "_timeout"}, timeout, t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctl", {main_wr, busy, done, pass, timeout, d_rd}, 0);
    chk("rst_data", main_data, 0);
    chk("rst_cnt", {sent_cnt, recv_cnt, err_cnt}, 0);
    reset = 1'b0;

    run(1'b0, 8'd8);
    chk("busy_run", busy, 1);
    wait_done();
    chk_result("basic", 8, 8, 0, 1'b1, 1'b0);
    chk_log(8, 1'b0);
    chk("busy_idle", busy, 0);
    @(negedge clk);
    chk("done_pulse", {done, 8'(dones)}, {1'b0, 8'd1});

    run(1'b0, 8'd8);
    wait_pushes(3);
    main_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d", i), {main_wr, main_data}, {1'b0, 6'h33});
    end
    main_full = 1'b0;
    wait_done();
    chk_result("stall", 8, 8, 0, 1'b1, 1'b0);
    chk_log(8, 1'b0);

    mis_en = 1'b1;
    run(1'b0, 8'd8);
    wait_done();
    chk_result("misroute", 8, 8, MIS_ERR, 1'b0, 1'b0);
    mis_en = 1'b0;

    d_error = 4'b1000;
    run(1'b0, 8'd8);
    wait_done();
    chk_result("derr", 8, 6, 0, 1'b0, 1'b1);
    d_error = '0;

    run(1'b0, 8'd0);
    chk("zero_early", done, 0);
    @(negedge clk);
    chk("zero_done", {done, pass, timeout}, 3'b110);
    chk("zero_nowr", plog.size(), 0);

    run(1'b0, 8'd4);
    @(negedge clk) begin
      num_words = 8'd20;
      start = 1'b1;
    end
    @(negedge clk) start = 1'b0;
    wait_done();
    chk_result("ignore", 4, 4, 0, 1'b1, 1'b0);

    run(1'b1, 8'd6);
    wait_done();
    chk_result("lfsr", 6, 6, 0, 1'b1, 1'b0);
    chk_log(6, 1'b1);

    swap_en = 1'b1;
    run(1'b0, 8'd8);
    wait_done();
    chk_result("swap", 8, 8, SWAP_ERR, SWAP_ERR == 0, 1'b0);
    swap_en = 1'b0;

    run(1'b0, 8'd8);
    wait_pushes(3);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_ctl", {main_wr, busy, done, pass, timeout, d_rd}, 0);
    chk("mrst_data", main_data, 0);
    chk("mrst_cnt", {sent_cnt, recv_cnt, err_cnt}, 0);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst_nodone", {8'(dones), busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/traffic_gen_chk.md
Name: traffic_gen_chk

Overview:
Synthesizable, parametrised stimulus-and-check engine for the QoS interconnect (main FIFO -> demux -> NDEST destination FIFOs). It pushes a programmable number of words into the main FIFO while respecting back-pressure. It drains every destination FIFO and checks that each word arrived on the channel encoded in its destination field, and it reports per-run pass/fail. It replaces the fixed two-destination, hand-sequenced stimulus with a reusable block for NDEST channels and two payload modes.

Parameters:
BW, 6, word width (destination field plus payload)
SEL_W, 2, destination field width; field = data[BW-1 -: SEL_W]; NDEST = 2**SEL_W
CNT_W, 8, width of word counters and num_words
TO_CYC, 64, drain timeout in cycles without any read

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins a run when idle
mode  in  1  0: incrementing payload, round-robin destination; 1: 8-bit LFSR payload and destination
num_words  in  CNT_W  words to send, sampled on start
main_full  in  1  main FIFO full
main_wr  out  1  main FIFO push
main_data  out  BW  word pushed
d_empty  in  NDEST  per-destination FIFO empty
d_error  in  NDEST  per-destination FIFO error
d_rd  out  NDEST  per-destination pop
d_data  in  NDEST*BW  flat bus; channel i at [i*BW +: BW], valid one cycle after d_rd[i]
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
pass  out  1  run result, held until next start
timeout  out  1  drain timed out, held until next start
sent_cnt  out  CNT_W  words pushed this run
recv_cnt  out  CNT_W  words popped this run, all channels
err_cnt  out  CNT_W  routing mismatches this run

Behaviour:
- Reset takes effect on the first posedge with reset=1. All outputs go to 0, the FSM goes to IDLE, and the LFSR is set to 8'h01. Reset mid-run aborts the run with no done pulse.
- FSM states: IDLE, SEND, DRAIN, DONE.
- IDLE: on start, latch num_words and mode; clear counters, pass, timeout and the generator state.
  - num_words=0: go to DONE.
  - otherwise: go to SEND.
  - start is ignored in any other state.
- SEND:
  - main_wr = !main_full, registered per cycle; main_data holds the current word.
  - On each push: sent_cnt++, then advance the generator.
  - mode 0: destination = sent_cnt mod NDEST; payload = sent_cnt truncated.
  - mode 1: both fields taken from LFSR bits (taps x^8+x^6+x^5+x^4+1), LFSR steps once per push.
  - The word is never changed while main_full holds it off.
  - When sent_cnt reaches num_words: go to DRAIN.
- Read side (active in SEND and DRAIN):
  - d_rd[i] = !d_empty[i] && !d_error[i].
  - All channels may pop in the same cycle.
  - d_rd is registered one cycle as rd_q; on rd_q[i], sample channel i data, recv_cnt++.
  - If the destination field != i: err_cnt++.
  - Simultaneous pops on k channels add k to recv_cnt in one cycle.
- DRAIN:
  - When recv_cnt == sent_cnt and no rd_q is pending: go to DONE.
  - The idle counter resets on any rd_q. If it reaches TO_CYC: set timeout=1, go to DONE.
- DONE (one cycle): done=1; pass = (err_cnt==0 && !timeout && recv_cnt==sent_cnt). Go to IDLE.
- All counters saturate at 2**CNT_W-1; no wrap.
- d_error[i] permanently blocks reads on channel i, so the run ends by timeout.

Optional Feature:
TGC_SEQ_CHECK_EN
- Defined: each channel keeps an expected-payload register, mode 0 only.
  - A word whose payload is not the previous payload on that channel plus NDEST (first word: payload == i) increments err_cnt.
  - This flags reordering and loss inside a channel.
- Undefined: only the destination-field check is performed; the per-channel registers are absent.

Test Plan:
- NDEST=4, mode 0, num_words=8, no full, FIFOs return words one cycle after push -> main_data destination fields 0,1,2,3,0,1,2,3; done pulse; sent=recv=8, err=0, pass=1.
- main_full held high for 5 cycles mid-SEND -> main_wr=0 and main_data stable for those 5 cycles; run completes with pass=1.
- Channel 2 model routes one word to d_data[1] -> err_cnt=1, pass=0.
- d_error[3]=1 for the whole run, num_words=8 -> recv=6, timeout=1 at TO_CYC idle cycles, pass=0.
- num_words=0 -> done two cycles after start, pass=1, no main_wr; start during busy ignored.
- Reset asserted in SEND after 3 pushes -> next cycle all outputs 0, FSM IDLE, no done; with TGC_SEQ_CHECK_EN, swapping two words on channel 0 -> err_cnt=2.
